// File: rtl/vedic_mult_bcd_scan_pkg.sv
// Shared types, seven-segment patterns and the digit encoder for the multiplier/display block.
package vedic_mult_bcd_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Map one BCD nibble to its segment pattern; non-decimal nibbles go blank
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// Combinational Urdhva-Tiryagbhyam (vertically and crosswise) unsigned multiplier.
module vedic_mult_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned COLS = 2 * WIDTH - 1;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    logic [CW-1:0] col [COLS];

    // Crosswise step: gather every bit product a[i]&b[j] into the column of weight i+j
    always_comb begin
        for (int k = 0; k < COLS; k++) begin
            col[k] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                col[i+j] = col[i+j] + CW'(a[i] & b[j]);
            end
        end
    end

    // Vertical step: fold column sums together with their carries into the full product
    always_comb begin
        product = '0;
        for (int k = 0; k < COLS; k++) begin
            product = product + (PW'(col[k]) << k);
        end
    end

endmodule

// File: rtl/vedic_mult_bcd_scan.sv
// Multiply two operands, convert the product to BCD by double-dabble and scan it onto a
// multiplexed seven-segment display.
module vedic_mult_bcd_scan
    import vedic_mult_bcd_scan_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [2*WIDTH-1:0]  product,
    output logic [4*DIGITS-1:0] bcd,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned BW     = 4 * DIGITS;
    localparam int unsigned BIT_W  = $clog2(PW);
    localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [PW-1:0]      mult_out;
    logic [PW-1:0]      bin;
    logic [BW-1:0]      work;
    logic [BW-1:0]      work_adj;
    logic [BIT_W-1:0]   bit_cnt;
    logic               conv_last;
    logic [SCAN_W-1:0]  scan_cnt;
    logic               scan_wrap;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [6:0]         digit_seg [DIGITS];

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] w);
        logic [BW-1:0] r;
        r = w;
        for (int d = 0; d < DIGITS; d++) begin
            if (w[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = w[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    vedic_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (a_q),
        .b       (b_q),
        .product (mult_out)
    );

    assign work_adj  = add3(work);
    assign conv_last = (bit_cnt == BIT_W'(PW - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = CONV;
            CONV:    if (conv_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, product, BCD conversion and commit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            product <= '0;
            bin     <= '0;
            work    <= '0;
            bit_cnt <= '0;
            bcd     <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                MUL: begin
                    product <= mult_out;
                    bin     <= mult_out;
                    work    <= '0;
                    bit_cnt <= '0;
                end
                CONV: begin
                    work    <= {work_adj[BW-2:0], bin[PW-1]};
                    bin     <= bin << 1;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                DONE: begin
                    bcd <= work;
                end
                default: ;
            endcase
        end
    end

    // Per-digit segment patterns from the committed BCD, with optional leading-zero blanking
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (i != 0) && zero_above) begin
                digit_seg[i] = SEG_BLANK;
            end else begin
                digit_seg[i] = bcd_to_seg(bcd[4*i +: 4]);
            end
        end
    end

    // Digit index advance at the end of each scan slot
    always_comb begin
        scan_wrap = (scan_cnt == SCAN_W'(REFRESH_DIV - 1));
        idx_nxt   = idx;
        if (scan_wrap) begin
            idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // Free-running scan; seg and an are loaded together for the upcoming digit
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= DIGITS'(1);
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            idx      <= idx_nxt;
            an       <= DIGITS'(1) << idx_nxt;
            seg      <= digit_seg[idx_nxt];
        end
    end

endmodule

// File: tb/tb_vedic_mult_bcd_scan.sv
// Directed self-checking bench for vedic_mult_bcd_scan (WIDTH=8, DIGITS=5, REFRESH_DIV=4).
module tb_vedic_mult_bcd_scan;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [4:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    vedic_mult_bcd_scan #(
        .WIDTH       (8),
        .DIGITS      (5),
        .REFRESH_DIV (4),
        .BLANK_LZ    (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .bcd     (bcd),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Watch a full scan round; exp_seg packs the expected patterns {d4,d3,d2,d1,d0}
    task automatic check_scan(input logic [34:0] exp_seg);
        for (int c = 0; c < 20; c++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < 5; i++) begin
                if (an[i]) idx = i;
            end
            check("an_onehot", 32'($onehot(an)), 32'd1);
            if (idx >= 0) begin
                check($sformatf("seg_d%0d", idx), 32'(seg), 32'(exp_seg[7*idx +: 7]));
            end
            @(negedge clk);
        end
    endtask

    // One start pulse, measure latency to done, then verify results and display
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [31:0] exp_p,
                          input logic [31:0] exp_bcd, input logic [34:0] exp_seg);
        int lat;
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd18);
        check("done_seen", 32'(done), 32'd1);
        check("product", 32'(product), exp_p);
        check("bcd", 32'(bcd), exp_bcd);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check_scan(exp_seg);
    endtask

    initial begin
        int n_done;
        int first_done;
        int seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset values and the idle scan sequence
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_an", 32'(an), 32'h01);
        check("rst_seg", 32'(seg), 32'h3F);
        rst = 1'b0;
        for (int n = 1; n < 24; n++) begin
            int d;
            @(negedge clk);
            d = (n / 4) % 5;
            check("idle_an", 32'(an), 32'(1 << d));
            check("idle_seg", 32'(seg), (d == 0) ? 32'h3F : 32'h00);
        end

        // Full-scale, small and zero products
        run_op(8'd255, 8'd255, 32'd65025, 32'h65025, {7'h7D, 7'h6D, 7'h3F, 7'h5B, 7'h6D});
        run_op(8'd12,  8'd11,  32'd132,   32'h00132, {7'h00, 7'h00, 7'h06, 7'h4F, 7'h5B});
        run_op(8'd0,   8'd200, 32'd0,     32'h00000, {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F});

        // start held high for 30 cycles: no queuing, re-accepted right after idle
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        n_done = 0;
        first_done = -1;
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (c == 18) check("held_busy_idle", 32'(busy), 32'd0);
            if (c == 19) check("held_reaccept", 32'(busy), 32'd1);
            if (c == 29) begin
                check("held_done_count30", 32'(n_done), 32'd1);
                start = 1'b0;
            end
            if (c == 37) check("held_second_done", 32'(done), 32'd1);
        end
        check("held_first_done", 32'(first_done), 32'd18);
        check("held_done_total", 32'(n_done), 32'd2);
        check("held_product", 32'(product), 32'd15);
        check("held_bcd", 32'(bcd), 32'h00015);
        @(negedge clk);
        check_scan({7'h00, 7'h00, 7'h00, 7'h06, 7'h6D});

        // Reset during the fifth conversion cycle of 200*200
        @(negedge clk);
        a = 8'd200;
        b = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_an", 32'(an), 32'h01);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_bcd_after", 32'(bcd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic_mult_bcd_scan.md
VEDIC_MULT_BCD_SCAN -- requirements
Module: vedic_mult_bcd_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 SHALL have parameter DIGITS, default 5: displayed decimal digits; must satisfy 10^DIGITS > (2^WIDTH-1)^2.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000: clocks per digit scan slot, minimum 2.
REQ-004 SHALL have parameter BLANK_LZ, default 1: 1 = blank leading zeros, except that digit 0 is never blanked.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 a, b  input  WIDTH each  unsigned operands, captured on an accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a result is committed.
REQ-011 product  output  2*WIDTH  registered binary product of the last completed operation.
REQ-012 bcd  output  4*DIGITS  registered BCD of product; digit i occupies bits [4i+3:4i].
REQ-013 seg  output  7  active-high segments of the selected digit; bit order {g,f,e,d,c,b,a}.
REQ-014 an  output  DIGITS  one-hot, active-high digit select; an[i] selects bcd digit i.

Function
REQ-015 FSM states SHALL be IDLE, MUL, CONV and DONE.
REQ-016 IDLE->MUL SHALL occur on an edge where start=1, latching a and b.
REQ-017 start SHALL be ignored in MUL, CONV and DONE; no queuing.
REQ-018 MUL SHALL last one cycle: product register <= a*b (unsigned, full 2*WIDTH width, no truncation); the shift-add-3 working register is cleared.
REQ-019 CONV SHALL run exactly 2*WIDTH cycles of double-dabble: each cycle add 3 to every BCD nibble >= 5, then shift left one bit from product MSB first.
REQ-020 DONE SHALL last one cycle: bcd <= working register, done=1, then return to IDLE.
REQ-021 Latency SHALL be fixed: with start accepted at edge k, done is high in the cycle after edge k+2*WIDTH+2 (18 cycles for WIDTH=8).
REQ-022 product SHALL change only in MUL, and bcd only in DONE.
REQ-023 Display SHALL always show the committed bcd; intermediate conversion values are never displayed.
REQ-024 Scan counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index advances by 1 and wraps from DIGITS-1 to 0.
REQ-025 Scanning SHALL be free-running and independent of FSM state.
REQ-026 seg SHALL encode the digit selected by an using standard 0-9 patterns (0 = 0111111, 1 = 0000110, 8 = 1111111).
REQ-027 Nibble values 10-15 SHALL produce a blank seg (0000000).
REQ-028 With BLANK_LZ=1, digit i > 0 SHALL be blank when it and all higher digits are zero.
REQ-029 seg and an SHALL be registered, updating together on the same edge.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, busy=0, done=0, product=0, bcd=0, working register=0.
REQ-031 On rst=1 at an edge: scan counter=0, digit index=0, an=1 (digit 0), seg=0111111.
REQ-032 rst SHALL override start and any in-progress operation; the aborted result is never committed and done never pulses for it.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, the 7-bit segment pattern constants and a bcd-to-seg function.
REQ-034 Multiplication SHALL be a sub-module vedic_mult_core #(WIDTH), purely combinational Urdhva-Tiryagbhyam, output 2*WIDTH bits.
REQ-035 The FSM, the double-dabble logic and the scan logic SHALL reside in vedic_mult_bcd_scan.

Verification
REQ-036 Use WIDTH=8, DIGITS=5, REFRESH_DIV=4. a=255, b=255, start pulse -> done exactly 18 cycles later; product=65025; bcd=0x65025.
REQ-037 a=12, b=11 -> product=132, bcd=0x00132; the scan shows digits 2,3,1 on an[0..2] and blank seg on an[3], an[4].
REQ-038 a=0, b=200 -> product=0; digit 0 shows 0111111 and digits 1-4 are blank.
REQ-039 start held high for 30 cycles with a=3, b=5 -> exactly one done in the first 18 cycles, then a new operation is accepted the cycle after IDLE; bcd=0x00015.
REQ-040 rst asserted in CONV cycle 5 of a 200*200 run -> next cycle busy=0, bcd=0, product=0, an=00001; no done pulse.
REQ-041 Idle after reset with REFRESH_DIV=4 -> an sequence 00001,00010,00100,01000,10000,00001, with each value held 4 cycles.
